fetch_unit: RTL and testbench

//  Instruction-fetch front end for the core. Owns the fetch PC and issues
//  in-order requests to a variable-latency instruction memory.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                 |
// | Brief    : imem request/response, redirect and decode handshake bundle.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    // master: the fetch unit; slave: memory, branch unit and decode
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_addr, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_addr, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Brief    : Fetch PC owner, in-order imem requester and PC-tagged buffer. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_unit_if.master      bus
);
    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W-1:0] r_alloc_ptr;
    logic [c_PTR_W-1:0] r_fill_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_alloc_cnt;
    logic [c_CNT_W-1:0] r_pend_cnt;
    logic [c_CNT_W-1:0] r_drops;
    logic [c_CNT_W-1:0] w_drops_next;

    logic [ADDR_W-1:0]  r_ent_pc   [DEPTH];
    logic [DATA_W-1:0]  r_ent_data [DEPTH];
    logic [DEPTH-1:0]   r_ent_filled;

    logic w_req_valid;
    logic w_req_hs;
    logic w_resp_fetch;
    logic w_fill;
    logic w_drop_resp;
    logic w_inst_valid;
    logic w_pop;

    // A response in FETCH always belongs to the oldest unfilled entry; under a
    // same-cycle redirect it is still consumed, just not stored.
    assign w_req_hs     = w_req_valid && bus.imem_req_ready;
    assign w_resp_fetch = (r_state == c_FETCH) && bus.imem_resp_valid && (r_pend_cnt != '0);
    assign w_fill       = w_resp_fetch && !bus.redirect_valid;
    assign w_drop_resp  = (r_state == c_FLUSH) && bus.imem_resp_valid && (r_drops != '0);
    assign w_inst_valid = (r_alloc_cnt != '0) && r_ent_filled[r_rd_ptr];
    assign w_pop        = w_inst_valid && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        w_drops_next = r_drops;
        if (bus.redirect_valid && (r_state == c_FETCH)) begin
            w_drops_next = r_pend_cnt - c_CNT_W'(w_resp_fetch);
        end else if (r_state == c_FLUSH) begin
            w_drops_next = r_drops - c_CNT_W'(w_drop_resp);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  w_state_next = c_FETCH;
            c_FETCH: if (bus.redirect_valid && (w_drops_next != '0)) w_state_next = c_FLUSH;
            c_FLUSH: if (w_drops_next == '0) w_state_next = c_FETCH;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_req_valid = (r_state == c_FETCH) && (r_alloc_cnt < c_DEPTH_CNT) && !bus.redirect_valid;
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = r_ent_data[r_rd_ptr];
    assign bus.inst_pc        = r_ent_pc[r_rd_ptr];

    // ---------------- PC, pointers and buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_alloc_ptr  <= '0;
            r_fill_ptr   <= '0;
            r_rd_ptr     <= '0;
            r_alloc_cnt  <= '0;
            r_pend_cnt   <= '0;
            r_drops      <= '0;
            r_ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_pc[i]   <= '0;
                r_ent_data[i] <= '0;
            end
        end else begin
            r_drops <= w_drops_next;
            if (bus.redirect_valid) begin
                // Everything buffered or requested before this point is stale.
                r_pc         <= bus.redirect_addr;
                r_alloc_ptr  <= '0;
                r_fill_ptr   <= '0;
                r_rd_ptr     <= '0;
                r_alloc_cnt  <= '0;
                r_pend_cnt   <= '0;
                r_ent_filled <= '0;
            end else begin
                if (w_req_hs) begin
                    r_pc                    <= r_pc + ADDR_W'(4);
                    r_ent_pc[r_alloc_ptr]   <= r_pc;
                    r_ent_filled[r_alloc_ptr] <= 1'b0;
                    r_alloc_ptr             <= r_alloc_ptr + 1'b1;
                end
                if (w_fill) begin
                    r_ent_data[r_fill_ptr]   <= bus.imem_resp_data;
                    r_ent_filled[r_fill_ptr] <= 1'b1;
                    r_fill_ptr               <= r_fill_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_ent_filled[r_rd_ptr] <= 1'b0;
                    r_rd_ptr               <= r_rd_ptr + 1'b1;
                end
                r_alloc_cnt <= r_alloc_cnt + c_CNT_W'(w_req_hs) - c_CNT_W'(w_pop);
                r_pend_cnt  <= r_pend_cnt + c_CNT_W'(w_req_hs) - c_CNT_W'(w_fill);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                 |
// | Brief    : Directed self-checking bench for fetch_unit.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;

    logic [7:0]  got_pc   [$];
    logic [31:0] got_data [$];
    logic [7:0]  req_q    [$];

    fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(2), .RESET_PC(8'h00)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // In-order memory model: response data encodes the address it came from.
    logic [7:0] m_addr;
    logic       m_hs;
    logic       m_rv;
    int         m_cyc;
    logic [7:0] q_addr [$];
    int         q_due  [$];
    initial begin
        m_cyc = 0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            m_hs   = bus.imem_req_valid && bus.imem_req_ready;
            m_addr = bus.imem_req_addr;
            m_rv   = bus.imem_resp_valid;
            @(posedge clk); #1;
            m_cyc++;
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
            end else begin
                if (m_rv && q_addr.size() > 0) begin
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end
                if (m_hs) begin
                    q_addr.push_back(m_addr);
                    q_due.push_back(m_cyc + lat - 1);
                end
            end
            if (rst_n && q_addr.size() > 0 && q_due[0] <= m_cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = 32'hC0DE_0000 | {24'h0, q_addr[0]};
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = '0;
            end
        end
    end

    // Records what decode accepts and which addresses are requested.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                    got_pc.push_back(bus.inst_pc);
                    got_data.push_back(bus.inst_data);
                end
                if (bus.imem_req_valid && bus.imem_req_ready) req_q.push_back(bus.imem_req_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_data.delete();
        req_q.delete();
    endtask

    // Leaves the caller in the drive slot of cycle 0 (the cycle of release).
    task automatic do_reset(input int l, input logic rdy);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.inst_ready     = rdy;
        lat = l;
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] first, input int n);
        logic [7:0] e;
        for (int k = 0; k < 80 && got_pc.size() < n; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_count"}, 64'(got_pc.size() >= n), 64'd1);
        for (int i = 0; i < n; i++) begin
            e = first + 8'(4 * i);
            if (i < got_pc.size()) begin
                chk($sformatf("%s_pc%0d", tag, i), 64'(got_pc[i]), 64'(e));
                chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(32'hC0DE_0000 | {24'h0, e}));
            end
        end
    endtask

    int         first_cyc;
    logic [7:0] pc_a;
    logic [7:0] pc_b;
    logic [31:0] data_b;

    initial begin
        n_cmp = 0;
        n_err = 0;
        lat   = 1;
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.inst_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid),     64'd0);
        chk("rst_inst_data",  64'(bus.inst_data),      64'd0);
        chk("rst_inst_pc",    64'(bus.inst_pc),        64'd0);

        // Streaming with single-cycle memory.
        do_reset(1, 1'b1);
        first_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.inst_valid && first_cyc < 0) first_cyc = k;
        end
        chk("t1_first_valid_cycle", 64'(first_cyc), 64'd3);
        check_stream("t1", 8'h00, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_q.size()) chk($sformatf("t1_req%0d", i), 64'(req_q[i]), 64'(4 * i));
        end

        // Decode stalled: two credits, then no more requests; outputs held.
        do_reset(1, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 4) pc_a = bus.inst_pc;
            if (k == 10) begin
                pc_b   = bus.inst_pc;
                data_b = bus.inst_data;
                chk("t2_req_valid_low", 64'(bus.imem_req_valid), 64'd0);
                chk("t2_inst_valid",    64'(bus.inst_valid),     64'd1);
            end
        end
        chk("t2_req_count", 64'(req_q.size()), 64'd2);
        chk("t2_pc_early",  64'(pc_a),   64'h00);
        chk("t2_pc_late",   64'(pc_b),   64'h00);
        chk("t2_data_late", 64'(data_b), 64'hC0DE_0000);
        tick();
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 20 && req_q.size() < 3; k++) begin
            @(negedge clk); #1;
        end
        chk("t2_resume_seen", 64'(req_q.size() >= 3), 64'd1);
        if (req_q.size() >= 3) chk("t2_resume_addr", 64'(req_q[2]), 64'h08);
        check_stream("t2", 8'h00, 4);

        // 3-cycle memory, redirect with two requests outstanding: drops = 2.
        do_reset(3, 1'b1);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h40;
        @(negedge clk);
        chk("t3_no_req_redirect", 64'(bus.imem_req_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_flush_c4", 64'(bus.imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t3_flush_c5", 64'(bus.imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t3_resume_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("t3_resume_addr",  64'(bus.imem_req_addr),  64'h40);
        check_stream("t3", 8'h40, 2);

        // Redirect coincides with the first response: it is discarded, one drop left.
        do_reset(3, 1'b1);
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h60;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4a_flush_one", 64'(bus.imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t4a_resume_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("t4a_resume_addr",  64'(bus.imem_req_addr),  64'h60);
        check_stream("t4a", 8'h60, 2);

        // Redirect with a pop and a response in the same cycle. With two entries
        // one is the popped filled one, so only one is unfilled and its response
        // lands now: nothing remains to drop and fetch restarts next cycle.
        do_reset(1, 1'b1);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h80;
        @(negedge clk);
        chk("t4b_pop_offered", 64'(bus.inst_valid), 64'd1);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4b_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("t4b_req_addr",  64'(bus.imem_req_addr),  64'h80);
        check_stream("t4b", 8'h80, 3);

        // PC wrap past the top of the 8-bit space.
        do_reset(1, 1'b1);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'hF8;
        tick();
        bus.redirect_valid = 1'b0;
        check_stream("t5", 8'hF8, 3);

        // Asynchronous reset while flushing.
        do_reset(3, 1'b1);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h20;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (2) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h60;
        tick();
        bus.redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t6_inst_valid", 64'(bus.inst_valid),    64'd0);
        chk("t6_inst_data",  64'(bus.inst_data),     64'd0);
        chk("t6_inst_pc",    64'(bus.inst_pc),       64'd0);
        lat = 1;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
        check_stream("t6", 8'h00, 2);
        if (req_q.size() > 0) chk("t6_first_req", 64'(req_q[0]), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
